// File: rtl/ac97_pkg.sv
// ac97_pkg: shared constants, field indices and types for the AC-link
// input-direction deframer.
//   - frame geometry (tag + 12 slots = 256 bits)
//   - slot1/slot2 field positions
//   - deframer FSM state type
//   - slot boundary helper functions (bit positions within a frame)
package ac97_pkg;

  localparam int TAG_BITS   = 16;
  localparam int SLOT_BITS  = 20;
  localparam int NUM_SLOTS  = 12;
  localparam int FRAME_BITS = TAG_BITS + SLOT_BITS * NUM_SLOTS;

  localparam logic [7:0] LAST_BIT = 8'(FRAME_BITS - 1);
  localparam logic [7:0] TAG_LAST = 8'(TAG_BITS - 1);

  // slot1: register address and slot-request bits
  localparam int ADDR_HI = 18;
  localparam int ADDR_LO = 12;
  localparam int REQ_HI  = 11;
  localparam int REQ_LO  = 2;

  // slot2: register read-back data
  localparam int DATA_HI = 19;
  localparam int DATA_LO = 4;

  typedef enum logic {HUNT, LOCKED} state_t;

  // First bit of slot n (1..12) within the frame.
  function automatic logic [7:0] slot_start(input int n);
    return 8'(TAG_BITS + SLOT_BITS * (n - 1));
  endfunction

  // Last bit of slot n; the slot word is complete once this bit is shifted in.
  function automatic logic [7:0] slot_last(input int n);
    return slot_start(n) + 8'(SLOT_BITS - 1);
  endfunction

endpackage

// File: rtl/ac97_deframer_if.sv
// ac97_deframer_if: AC-link input pins plus the deframed frame outputs.
//   master: the deframer (takes ac97_sync/ac97_sdata_in, drives results)
//   slave : the consumer / link driver side
//   ac97_sync, ac97_sdata_in : looped-back SYNC and codec serial data
//   frame_strobe, locked, sync_err : framing status
//   codec_ready, tag_valid, status_* , slot_req, pcm_* : frame contents
interface ac97_deframer_if #(
  parameter int PCM_W = 20
);
  logic             ac97_sync;
  logic             ac97_sdata_in;
  logic             frame_strobe;
  logic             locked;
  logic             sync_err;
  logic             codec_ready;
  logic [11:0]      tag_valid;
  logic             status_valid;
  logic [6:0]       status_addr;
  logic [9:0]       slot_req;
  logic [15:0]      status_data;
  logic [PCM_W-1:0] pcm_l;
  logic             pcm_l_valid;
  logic [PCM_W-1:0] pcm_r;
  logic             pcm_r_valid;

  modport master (
    input  ac97_sync, ac97_sdata_in,
    output frame_strobe, locked, sync_err, codec_ready, tag_valid,
           status_valid, status_addr, slot_req, status_data,
           pcm_l, pcm_l_valid, pcm_r, pcm_r_valid
  );

  modport slave (
    output ac97_sync, ac97_sdata_in,
    input  frame_strobe, locked, sync_err, codec_ready, tag_valid,
           status_valid, status_addr, slot_req, status_data,
           pcm_l, pcm_l_valid, pcm_r, pcm_r_valid
  );
endinterface

// File: rtl/ac97_slot_shift.sv
// ac97_slot_shift: 20-bit serial-in shift register and slot-boundary decode.
//   clk, rst : bit clock (rising edge), async active-high reset
//   en       : frame alignment valid (load strobes are suppressed otherwise)
//   bit_in   : sampled serial data bit for this cycle
//   bit_cnt  : position of bit_in within the frame
//   word     : shift register contents including bit_in (MSB first)
//   ld_tag   : word[15:0] holds the complete tag this cycle
//   ld_slot  : ld_slot[n-1] -> word holds the complete slot n (n = 1..4)
module ac97_slot_shift
  import ac97_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 bit_in,
  input  logic [7:0]           bit_cnt,
  output logic [SLOT_BITS-1:0] word,
  output logic                 ld_tag,
  output logic [3:0]           ld_slot
);

  logic [SLOT_BITS-1:0] sr;

  // Expose the word with the current bit already appended so staging can
  // capture a slot on the same edge that its last bit arrives.
  assign word = {sr[SLOT_BITS-2:0], bit_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= word;
  end

  always_comb begin
    ld_slot = '0;
    ld_tag  = en && (bit_cnt == TAG_LAST);
    for (int n = 1; n <= 4; n++) begin
      ld_slot[n-1] = en && (bit_cnt == slot_last(n));
    end
  end

endmodule

// File: rtl/ac97_deframer.sv
// ac97_deframer: AC-link codec-to-controller frame receiver.
//   ac97_bitclk : codec bit clock, the only clock
//   ac97_rst    : async active-high reset
//   bus         : ac97_deframer_if.master (link inputs, frame outputs)
// Inputs are sampled on the falling edge; framing, staging and outputs run
// on the rising edge. Outputs are delivered together once per good frame.
module ac97_deframer
  import ac97_pkg::*;
#(
  parameter int PCM_W = 20
) (
  input  logic            ac97_bitclk,
  input  logic            ac97_rst,
  ac97_deframer_if.master bus
);

  logic                 s_sync, s_data, prev_sync, rise;
  state_t               state;
  logic [7:0]           bit_cnt;
  logic [SLOT_BITS-1:0] word;
  logic                 ld_tag;
  logic [3:0]           ld_slot;

  logic [TAG_BITS-1:3]  stg_tag;
  logic [6:0]           stg_addr;
  logic [9:0]           stg_req;
  logic [15:0]          stg_data;
  logic [PCM_W-1:0]     stg_l, stg_r;

  // Falling-edge capture gives the codec's rising-edge data half a cycle to settle.
  always_ff @(negedge ac97_bitclk or posedge ac97_rst) begin
    if (ac97_rst) begin
      s_sync <= 1'b0;
      s_data <= 1'b0;
    end else begin
      s_sync <= bus.ac97_sync;
      s_data <= bus.ac97_sdata_in;
    end
  end

  assign rise = s_sync & ~prev_sync;

  ac97_slot_shift u_shift (
    .clk     (ac97_bitclk),
    .rst     (ac97_rst),
    .en      (state == LOCKED),
    .bit_in  (s_data),
    .bit_cnt (bit_cnt),
    .word    (word),
    .ld_tag  (ld_tag),
    .ld_slot (ld_slot)
  );

  // Staging: each field is captured as soon as its slot completes; a frame
  // that is later discarded simply gets overwritten by the next one.
  always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
    if (ac97_rst) begin
      stg_tag  <= '0;
      stg_addr <= '0;
      stg_req  <= '0;
      stg_data <= '0;
      stg_l    <= '0;
      stg_r    <= '0;
    end else begin
      if (ld_tag) stg_tag <= word[TAG_BITS-1:3];
      if (ld_slot[0]) begin
        stg_addr <= word[ADDR_HI:ADDR_LO];
        stg_req  <= word[REQ_HI:REQ_LO];
      end
      if (ld_slot[1]) stg_data <= word[DATA_HI:DATA_LO];
      if (ld_slot[2]) stg_l <= word[SLOT_BITS-1 -: PCM_W];
      if (ld_slot[3]) stg_r <= word[SLOT_BITS-1 -: PCM_W];
    end
  end

  // Framing FSM and output registers. A rise on the last bit closes a good
  // frame and delivers it; any other rise realigns, and a missing rise
  // drops back to hunting.
  always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
    if (ac97_rst) begin
      state            <= HUNT;
      bit_cnt          <= '0;
      prev_sync        <= 1'b0;
      bus.frame_strobe <= 1'b0;
      bus.locked       <= 1'b0;
      bus.sync_err     <= 1'b0;
      bus.codec_ready  <= 1'b0;
      bus.tag_valid    <= '0;
      bus.status_valid <= 1'b0;
      bus.status_addr  <= '0;
      bus.slot_req     <= '0;
      bus.status_data  <= '0;
      bus.pcm_l        <= '0;
      bus.pcm_l_valid  <= 1'b0;
      bus.pcm_r        <= '0;
      bus.pcm_r_valid  <= 1'b0;
    end else begin
      prev_sync        <= s_sync;
      bus.frame_strobe <= 1'b0;
      bus.sync_err     <= 1'b0;
      bus.status_valid <= 1'b0;
      case (state)
        HUNT: begin
          if (rise) begin
            state      <= LOCKED;
            bit_cnt    <= '0;
            bus.locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (rise) begin
              bus.frame_strobe <= 1'b1;
              bus.codec_ready  <= stg_tag[15];
              bus.tag_valid    <= stg_tag[14:3];
              bus.status_valid <= stg_tag[14] & stg_tag[13];
              bus.status_addr  <= stg_addr;
              bus.slot_req     <= stg_req;
              bus.status_data  <= stg_data;
              bus.pcm_l        <= stg_l;
              bus.pcm_l_valid  <= stg_tag[12];
              bus.pcm_r        <= stg_r;
              bus.pcm_r_valid  <= stg_tag[11];
            end else begin
              bus.sync_err <= 1'b1;
              bus.locked   <= 1'b0;
              state        <= HUNT;
            end
          end else if (rise) begin
            bus.sync_err <= 1'b1;
            bit_cnt      <= '0;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule
